multi_obj_motion_engine: RTL and testbench

Per-frame position update engine for up to N_OBJ sprites on the VGA pixel grid. It holds every object's X/Y in internal registers. On a frame tick it sweeps all objects in order, one per clock, and moves each by STEP pixels along one of 8 directions, forward or backward. Screen edges are handled by wrap-around or clamping. Each new position is streamed to the draw/erase datapath and is also exposed as a flat register bank for collision logic.

---
 rtl/multi_obj_motion_engine_if.sv | 33 +++
 rtl/multi_obj_motion_engine.sv | 189 ++++++++++++++++++
 tb/tb_multi_obj_motion_engine.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_obj_motion_engine_if.sv
// Request/status bundle between a frame controller and the sprite motion engine.
// The controller drives the master side; the engine implements the slave side.
interface multi_obj_motion_engine_if #(
  parameter int N_OBJ = 4,
  parameter int XW    = 8,
  parameter int YW    = 7
);
  logic                  start;
  logic [2*N_OBJ-1:0]    go;
  logic [3*N_OBJ-1:0]    dir;
  logic                  load;
  logic [3:0]            load_idx;
  logic [XW-1:0]         load_x;
  logic [YW-1:0]         load_y;
  logic                  busy;
  logic                  done;
  logic                  upd_valid;
  logic [3:0]            upd_idx;
  logic [XW-1:0]         upd_x;
  logic [YW-1:0]         upd_y;
  logic [XW*N_OBJ-1:0]   pos_x;
  logic [YW*N_OBJ-1:0]   pos_y;

  modport master (
    output start, go, dir, load, load_idx, load_x, load_y,
    input  busy, done, upd_valid, upd_idx, upd_x, upd_y, pos_x, pos_y
  );

  modport slave (
    input  start, go, dir, load, load_idx, load_x, load_y,
    output busy, done, upd_valid, upd_idx, upd_x, upd_y, pos_x, pos_y
  );
endinterface

// File: rtl/multi_obj_motion_engine.sv
// Per-frame sprite position updater: one object per clock, 8 directions, wrap or clamp.
// state | meaning
// IDLE  | waiting for start; direct position loads accepted
// SWEEP | updating object idx, one per clock, streaming each result
module multi_obj_motion_engine #(
  parameter int N_OBJ  = 4,
  parameter int XMAX   = 160,
  parameter int YMAX   = 120,
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int STEP   = 1,
  parameter int WRAP   = 1,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input logic clock,
  input logic reset,
  multi_obj_motion_engine_if.slave bus
);
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [3:0]             LAST   = 4'(N_OBJ - 1);
  localparam logic [4:0]             NOBJ   = 5'(N_OBJ);
  localparam logic [XW-1:0]          XLIM   = XW'(XMAX - 1);
  localparam logic [YW-1:0]          YLIM   = YW'(YMAX - 1);
  localparam logic [XW-1:0]          XINIT  = XW'(INIT_X);
  localparam logic [YW-1:0]          YINIT  = YW'(INIT_Y);
  localparam logic signed [XW+1:0]   XMAX_S = (XW+2)'(XMAX);
  localparam logic signed [YW+1:0]   YMAX_S = (YW+2)'(YMAX);
  localparam logic signed [XW+1:0]   XSTEP  = (XW+2)'(STEP);
  localparam logic signed [YW+1:0]   YSTEP  = (YW+2)'(STEP);
  localparam logic signed [1:0]      P1     = 2'sb01;
  localparam logic signed [1:0]      M1     = 2'sb11;
  localparam logic signed [1:0]      Z0     = 2'sb00;

  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_next;

  logic [XW-1:0] px [N_OBJ];
  logic [YW-1:0] py [N_OBJ];
  logic [1:0]    go_s [N_OBJ];
  logic [2:0]    dir_s [N_OBJ];
  logic [3:0]    idx;
  logic [IW-1:0] sel, lsel;
  logic          snap, sweep_en, load_ok;
  logic signed [1:0]    ux, uy, mvx, mvy;
  logic signed [XW+1:0] dx, nx_raw;
  logic signed [YW+1:0] dy, ny_raw;
  logic [XW-1:0]        nx, lx;
  logic [YW-1:0]        ny, ly;
  logic                 done_r, upd_valid_r;
  logic [3:0]           upd_idx_r;
  logic [XW-1:0]        upd_x_r;
  logic [YW-1:0]        upd_y_r;
  logic [XW*N_OBJ-1:0]  pos_x_f;
  logic [YW*N_OBJ-1:0]  pos_y_f;

  assign sel  = idx[IW-1:0];
  assign lsel = bus.load_idx[IW-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap       = 1'b0;
    sweep_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = SWEEP;
          snap       = 1'b1;
        end
      end
      SWEEP: begin
        sweep_en = 1'b1;
        if (idx == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_ok = (state == IDLE) && bus.load && ({1'b0, bus.load_idx} < NOBJ);
  assign lx = (bus.load_x > XLIM) ? XLIM : bus.load_x;
  assign ly = (bus.load_y > YLIM) ? YLIM : bus.load_y;

  // Unit vector for the object being swept; backward negates, stop zeroes.
  always_comb begin
    ux = Z0;
    uy = Z0;
    case (dir_s[sel])
      3'd0: begin ux = P1; uy = Z0; end
      3'd1: begin ux = P1; uy = M1; end
      3'd2: begin ux = Z0; uy = P1; end
      3'd3: begin ux = M1; uy = M1; end
      3'd4: begin ux = M1; uy = Z0; end
      3'd5: begin ux = M1; uy = P1; end
      3'd6: begin ux = Z0; uy = M1; end
      3'd7: begin ux = P1; uy = P1; end
    endcase
    mvx = Z0;
    mvy = Z0;
    if (go_s[sel] == 2'b11) begin
      mvx = ux;
      mvy = uy;
    end else if (go_s[sel] == 2'b10) begin
      mvx = -ux;
      mvy = -uy;
    end
    dx = '0;
    dy = '0;
    if (mvx == P1) dx = XSTEP;
    else if (mvx == M1) dx = -XSTEP;
    if (mvy == P1) dy = YSTEP;
    else if (mvy == M1) dy = -YSTEP;
    nx_raw = $signed({2'b00, px[sel]}) + dx;
    ny_raw = $signed({2'b00, py[sel]}) + dy;
  end

  // Sign bit flags underflow; STEP < screen size keeps one correction sufficient.
  always_comb begin
    if (nx_raw[XW+1])            nx = (WRAP != 0) ? XW'(nx_raw + XMAX_S) : '0;
    else if (nx_raw >= XMAX_S)   nx = (WRAP != 0) ? XW'(nx_raw - XMAX_S) : XLIM;
    else                         nx = nx_raw[XW-1:0];
    if (ny_raw[YW+1])            ny = (WRAP != 0) ? YW'(ny_raw + YMAX_S) : '0;
    else if (ny_raw >= YMAX_S)   ny = (WRAP != 0) ? YW'(ny_raw - YMAX_S) : YLIM;
    else                         ny = ny_raw[YW-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx         <= '0;
      done_r      <= 1'b0;
      upd_valid_r <= 1'b0;
      upd_idx_r   <= '0;
      upd_x_r     <= '0;
      upd_y_r     <= '0;
      for (int k = 0; k < N_OBJ; k++) begin
        px[k]    <= XINIT;
        py[k]    <= YINIT;
        go_s[k]  <= '0;
        dir_s[k] <= '0;
      end
    end else begin
      done_r      <= 1'b0;
      upd_valid_r <= 1'b0;
      if (load_ok) begin
        px[lsel] <= lx;
        py[lsel] <= ly;
      end
      if (snap) begin
        idx <= '0;
        for (int k = 0; k < N_OBJ; k++) begin
          go_s[k]  <= bus.go[2*k +: 2];
          dir_s[k] <= bus.dir[3*k +: 3];
        end
      end
      if (sweep_en) begin
        px[sel]     <= nx;
        py[sel]     <= ny;
        upd_valid_r <= 1'b1;
        upd_idx_r   <= idx;
        upd_x_r     <= nx;
        upd_y_r     <= ny;
        done_r      <= (idx == LAST);
        idx         <= idx + 4'd1;
      end
    end
  end

  always_comb begin
    pos_x_f = '0;
    pos_y_f = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      pos_x_f[k*XW +: XW] = px[k];
      pos_y_f[k*YW +: YW] = py[k];
    end
  end

  assign bus.busy      = (state == SWEEP);
  assign bus.done      = done_r;
  assign bus.upd_valid = upd_valid_r;
  assign bus.upd_idx   = upd_idx_r;
  assign bus.upd_x     = upd_x_r;
  assign bus.upd_y     = upd_y_r;
  assign bus.pos_x     = pos_x_f;
  assign bus.pos_y     = pos_y_f;
endmodule

// File: tb/tb_multi_obj_motion_engine.sv
// Runs three engine configurations (wrap step 1, clamp step 1, wrap step 3) in lockstep
// against a plain-arithmetic position model.
module tb_multi_obj_motion_engine;
  localparam int N  = 4;
  localparam int GW = 2 * N;
  localparam int DW = 3 * N;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic load  = 1'b0;
  logic [GW-1:0] go = '0;
  logic [DW-1:0] dir = '0;
  logic [3:0] load_idx = '0;
  logic [7:0] load_x = '0;
  logic [6:0] load_y = '0;

  int checks = 0;
  int failures = 0;

  int mx [3][N];
  int my [3][N];
  int step_c [3] = '{1, 1, 3};
  bit wrap_c [3] = '{1'b1, 1'b0, 1'b1};
  int dxv [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int dyv [8] = '{0, -1, 1, -1, 0, 1, -1, 1};

  always #5 clock = ~clock;

  multi_obj_motion_engine_if #(.N_OBJ(N), .XW(8), .YW(7)) b0 ();
  multi_obj_motion_engine_if #(.N_OBJ(N), .XW(8), .YW(7)) b1 ();
  multi_obj_motion_engine_if #(.N_OBJ(N), .XW(8), .YW(7)) b2 ();

  assign b0.start = start;  assign b1.start = start;  assign b2.start = start;
  assign b0.go = go;        assign b1.go = go;        assign b2.go = go;
  assign b0.dir = dir;      assign b1.dir = dir;      assign b2.dir = dir;
  assign b0.load = load;    assign b1.load = load;    assign b2.load = load;
  assign b0.load_idx = load_idx; assign b1.load_idx = load_idx; assign b2.load_idx = load_idx;
  assign b0.load_x = load_x; assign b1.load_x = load_x; assign b2.load_x = load_x;
  assign b0.load_y = load_y; assign b1.load_y = load_y; assign b2.load_y = load_y;

  multi_obj_motion_engine #(.N_OBJ(N))              dut0 (.clock(clock), .reset(reset), .bus(b0));
  multi_obj_motion_engine #(.N_OBJ(N), .WRAP(0))    dut1 (.clock(clock), .reset(reset), .bus(b1));
  multi_obj_motion_engine #(.N_OBJ(N), .STEP(3))    dut2 (.clock(clock), .reset(reset), .bus(b2));

  logic busy_o [3];
  logic done_o [3];
  logic uv_o [3];
  logic [3:0] ui_o [3];
  logic [7:0] ux_o [3];
  logic [6:0] uy_o [3];
  logic [8*N-1:0] px_o [3];
  logic [7*N-1:0] py_o [3];

  assign busy_o[0] = b0.busy;      assign busy_o[1] = b1.busy;      assign busy_o[2] = b2.busy;
  assign done_o[0] = b0.done;      assign done_o[1] = b1.done;      assign done_o[2] = b2.done;
  assign uv_o[0] = b0.upd_valid;   assign uv_o[1] = b1.upd_valid;   assign uv_o[2] = b2.upd_valid;
  assign ui_o[0] = b0.upd_idx;     assign ui_o[1] = b1.upd_idx;     assign ui_o[2] = b2.upd_idx;
  assign ux_o[0] = b0.upd_x;       assign ux_o[1] = b1.upd_x;       assign ux_o[2] = b2.upd_x;
  assign uy_o[0] = b0.upd_y;       assign uy_o[1] = b1.upd_y;       assign uy_o[2] = b2.upd_y;
  assign px_o[0] = b0.pos_x;       assign px_o[1] = b1.pos_x;       assign px_o[2] = b2.pos_x;
  assign py_o[0] = b0.pos_y;       assign py_o[1] = b1.pos_y;       assign py_o[2] = b2.pos_y;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int mv(input int c, input int d, input int step, input int lim, input bit wrap);
    int n;
    n = c + d * step;
    if (wrap) n = ((n % lim) + lim) % lim;
    else if (n < 0) n = 0;
    else if (n > lim - 1) n = lim - 1;
    return n;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < N; k++) begin
        mx[c][k] = 0;
        my[c][k] = 0;
      end
  endtask

  task automatic model_load(input int i, input int x, input int y);
    if (i < N)
      for (int c = 0; c < 3; c++) begin
        mx[c][i] = (x > 159) ? 159 : x;
        my[c][i] = (y > 119) ? 119 : y;
      end
  endtask

  task automatic check_all_pos(input string tag);
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < N; k++) begin
        chk($sformatf("%s c%0d pos_x%0d", tag, c, k), 32'(px_o[c][k*8 +: 8]), mx[c][k]);
        chk($sformatf("%s c%0d pos_y%0d", tag, c, k), 32'(py_o[c][k*7 +: 7]), my[c][k]);
      end
  endtask

  task automatic exp_pos(input string tag, input int c, input int k, input int x, input int y);
    chk($sformatf("%s c%0d o%0d x", tag, c, k), 32'(px_o[c][k*8 +: 8]), x);
    chk($sformatf("%s c%0d o%0d y", tag, c, k), 32'(py_o[c][k*7 +: 7]), y);
  endtask

  task automatic check_idle(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s c%0d busy", tag, c), 32'(busy_o[c]), 0);
      chk($sformatf("%s c%0d upd_valid", tag, c), 32'(uv_o[c]), 0);
      chk($sformatf("%s c%0d done", tag, c), 32'(done_o[c]), 0);
    end
  endtask

  task automatic do_load(input int i, input int x, input int y);
    load = 1'b1;
    load_idx = 4'(i);
    load_x = 8'(x);
    load_y = 7'(y);
    model_load(i, x, y);
    tick();
    load = 1'b0;
  endtask

  task automatic set_gd(input int k, input int g, input int d);
    go[2*k +: 2] = 2'(g);
    dir[3*k +: 3] = 3'(d);
  endtask

  // One full sweep starting this cycle; perturb exercises mid-sweep start/load/go changes.
  task automatic sweep(input bit perturb);
    logic [GW-1:0] gs;
    logic [DW-1:0] ds;
    int s, d;
    gs = go;
    ds = dir;
    start = 1'b1;
    if (load) model_load(int'(load_idx), int'(load_x), int'(load_y));
    tick();
    start = 1'b0;
    load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sweep E0 c%0d busy", c), 32'(busy_o[c]), 1);
      chk($sformatf("sweep E0 c%0d upd_valid", c), 32'(uv_o[c]), 0);
    end
    for (int k = 0; k < N; k++) begin
      if (perturb) begin
        go = GW'($urandom);
        dir = DW'($urandom);
        start = (k == N - 1) ? 1'b1 : 1'($urandom_range(0, 1));
        load = 1'b1;
        load_idx = 4'($urandom_range(0, N - 1));
        load_x = 8'($urandom);
        load_y = 7'($urandom);
      end
      tick();
      d = int'(ds[3*k +: 3]);
      s = (gs[2*k +: 2] == 2'b11) ? 1 : (gs[2*k +: 2] == 2'b10) ? -1 : 0;
      for (int c = 0; c < 3; c++) begin
        mx[c][k] = mv(mx[c][k], s * dxv[d], step_c[c], 160, wrap_c[c]);
        my[c][k] = mv(my[c][k], s * dyv[d], step_c[c], 120, wrap_c[c]);
        chk($sformatf("upd%0d c%0d upd_valid", k, c), 32'(uv_o[c]), 1);
        chk($sformatf("upd%0d c%0d upd_idx", k, c), 32'(ui_o[c]), k);
        chk($sformatf("upd%0d c%0d upd_x", k, c), 32'(ux_o[c]), mx[c][k]);
        chk($sformatf("upd%0d c%0d upd_y", k, c), 32'(uy_o[c]), my[c][k]);
        chk($sformatf("upd%0d c%0d done", k, c), 32'(done_o[c]), (k == N - 1) ? 1 : 0);
        chk($sformatf("upd%0d c%0d busy", k, c), 32'(busy_o[c]), (k == N - 1) ? 0 : 1);
      end
    end
    start = 1'b0;
    load = 1'b0;
    check_all_pos("post-sweep");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("reset c%0d upd_idx", c), 32'(ui_o[c]), 0);
      chk($sformatf("reset c%0d upd_x", c), 32'(ux_o[c]), 0);
      chk($sformatf("reset c%0d upd_y", c), 32'(uy_o[c]), 0);
    end
    check_all_pos("reset");

    // forward, corner wrap/clamp, backward diagonal
    do_load(0, 10, 20);
    do_load(1, 0, 0);
    do_load(2, 159, 119);
    do_load(3, 50, 50);
    set_gd(0, 3, 0); set_gd(1, 3, 3); set_gd(2, 3, 7); set_gd(3, 2, 1);
    sweep(1'b0);
    exp_pos("A", 0, 0, 11, 20);
    exp_pos("A", 0, 1, 159, 119);
    exp_pos("A", 0, 2, 0, 0);
    exp_pos("A", 0, 3, 49, 51);
    exp_pos("A", 1, 1, 0, 0);
    exp_pos("A", 1, 2, 159, 119);
    exp_pos("A", 2, 1, 157, 117);
    exp_pos("A", 2, 2, 2, 2);
    tick();
    check_idle("A idle");

    // clamp edges, backward off edge, stop code 01
    do_load(0, 0, 0);
    do_load(1, 159, 5);
    do_load(2, 159, 5);
    do_load(3, 77, 33);
    set_gd(0, 3, 3); set_gd(1, 3, 0); set_gd(2, 2, 0); set_gd(3, 1, 5);
    sweep(1'b0);
    exp_pos("B", 1, 0, 0, 0);
    exp_pos("B", 1, 1, 159, 5);
    exp_pos("B", 1, 2, 158, 5);
    exp_pos("B", 1, 3, 77, 33);
    exp_pos("B", 0, 3, 77, 33);

    // step 3 wrap, out-of-range index ignored, load coinciding with start
    do_load(9, 5, 5);
    do_load(0, 158, 0);
    do_load(1, 1, 2);
    do_load(2, 30, 40);
    set_gd(0, 3, 0); set_gd(1, 3, 3); set_gd(2, 0, 2); set_gd(3, 2, 4);
    load = 1'b1; load_idx = 4'd3; load_x = 8'd200; load_y = 7'd125;
    sweep(1'b0);
    exp_pos("C", 2, 0, 1, 0);
    exp_pos("C", 2, 1, 158, 119);
    exp_pos("C", 2, 2, 30, 40);
    exp_pos("C", 0, 3, 0, 119);
    exp_pos("C", 1, 3, 159, 119);
    exp_pos("C", 2, 3, 2, 119);
    tick();
    check_idle("C idle");

    // mid-sweep disturbances must leave the sweep and done count unchanged
    go = GW'($urandom);
    dir = DW'($urandom);
    sweep(1'b1);
    tick();
    check_idle("perturb idle");
    check_all_pos("perturb idle");

    // reset in the middle of a sweep
    go = GW'($urandom);
    dir = DW'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_idle("midreset");
    for (int c = 0; c < 3; c++)
      chk($sformatf("midreset c%0d upd_idx", c), 32'(ui_o[c]), 0);
    check_all_pos("midreset");
    tick();
    check_idle("midreset idle");

    for (int it = 0; it < 40; it++) begin
      int nl;
      nl = $urandom_range(0, 2);
      for (int j = 0; j < nl; j++)
        do_load($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 127));
      go = GW'($urandom);
      dir = DW'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        load = 1'b1;
        load_idx = 4'($urandom_range(0, 7));
        load_x = 8'($urandom);
        load_y = 7'($urandom);
      end
      sweep(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_idle("rand idle");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
